id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus load-use hazard detection. Latches the decode
//  control signals from the control unit, together with the operands,
//  immediate, register indices and funct fields, for the EX stage.
//  On a load-use hazard it inserts a bubble and stalls PC and IF/ID.
//  A branch-resolution flush squashes the latched instruction.
// PARAMETERS
//  XLEN        64  data/PC width (RV64: ld/sd)
//  REG_AW      5   register index width
//  CNT_W       16  width of bubble performance counter
// PORTS
//  clk            in   1       rising-edge clock
//  reset_n        in   1       asynchronous, active-low reset
//  flush          in   1       squash the ID instruction (taken branch in EX/MEM)
//  id_opcode      in   7       opcode of the ID instruction
//  id_alu_op      in   2       ALUOp from control unit
//  id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  in 1 each
//  id_pc          in   XLEN    PC of the ID instruction
//  id_rs1_data    in   XLEN    register-file read 1
//  id_rs2_data    in   XLEN    register-file read 2
//  id_imm         in   XLEN    sign-extended immediate
//  id_rs1, id_rs2, id_rd  in  REG_AW  register indices
//  id_funct3      in   3 ;  id_funct7  in 7
//  ex_* (out, same widths as the id_* above, one per field) registered copies
//  ex_valid       out  1       1 = real instruction in EX; 0 = bubble/reset/flush
//  pc_write       out  1       0 = hold PC (combinational)
//  if_id_write    out  1       0 = hold IF/ID (combinational)
//  bubble_count   out  CNT_W   hazard bubbles inserted since reset, saturating
// BEHAVIOUR
//  - Reset (reset_n=0, async): every ex_* output, ex_valid and bubble_count
//    are 0. pc_write=if_id_write=1 (ex_mem_read=0, so no hazard).
//  - uses_rs2 = id_opcode is 0110011 (R), 0100011 (S) or 1100011 (SB).
//    uses_rs1 = id_opcode is one of those or 0000011 (ld) or 0010011 (addi).
//  - hazard = ex_valid & ex_mem_read & (ex_rd!=0) &
//    ((uses_rs1 & ex_rd==id_rs1) | (uses_rs2 & ex_rd==id_rs2)).
//    hazard is combinational from registered state; it resolves in one cycle.
//  - pc_write = if_id_write = ~(hazard & ~flush).
//  - Each posedge, in priority order:
//    1. flush: all control outputs, ex_rd and ex_valid are 0. The data fields
//       take the id_* values (don't-care). The counter is unchanged.
//    2. hazard: bubble. Control outputs, ex_rd and ex_valid are 0. Data fields
//       take the id_* values. bubble_count += 1, saturating at 2^CNT_W-1.
//    3. Otherwise every ex_* takes its id_* value and ex_valid = 1.
//  - Latency: 1 cycle from the ID inputs to the ex_* outputs.
//  - A load-use stall lasts exactly 1 cycle: once the bubble is latched,
//    ex_mem_read=0 and the held instruction proceeds on the next edge.
//  - An unknown opcode arrives with zeroed controls and passes through with
//    ex_valid=1. It never triggers a hazard.
//  - Reset asserted mid-stall clears the state immediately. The first
//    instruction after reset release latches normally.
// TESTING
//  1. Reset then add x3,x1,x2: ex_reg_write=1, ex_alu_op=10, ex_valid=1,
//     ex_rd=3 one cycle later; pc_write stays 1.
//  2. ld x5,0(x1) then add x6,x5,x7: pc_write=if_id_write=0 for 1 cycle;
//     bubble latched (ex_valid=0, all control 0); bubble_count=1; add follows.
//  3. ld x0,.. then add x6,x0,x7: no stall, bubble_count stays 0.
//     ld x5 then addi x6,x5,4: stall. ld x5 then addi x6,x1,4 where
//     id_rs2 field=5: no stall (addi does not use rs2).
//  4. flush=1 together with a load-use hazard: pc_write=1, ex_valid=0,
//     bubble_count unchanged.
//  5. Preload bubble_count=16'hFFFF (force) plus one more hazard: stays FFFF.
//  6. Drop reset_n between clock edges during a stall: outputs 0 at once;
//     after release sd x2,8(x1): ex_mem_write=1, ex_alu_src=1, ex_reg_write=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Inserts a one-cycle bubble on load-use, squashes on flush, counts bubbles.
module id_ex_stage #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic [6:0]        id_opcode,
    input  logic [1:0]        id_alu_op,
    input  logic              id_branch,
    input  logic              id_mem_read,
    input  logic              id_mem_to_reg,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [2:0]        id_funct3,
    input  logic [6:0]        id_funct7,
    output logic [6:0]        ex_opcode,
    output logic [1:0]        ex_alu_op,
    output logic              ex_branch,
    output logic              ex_mem_read,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
    output logic              ex_valid,
    output logic              pc_write,
    output logic              if_id_write,
    output logic [CNT_W-1:0]  bubble_count
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_SB   = 7'b1100011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [6:0]        opcode;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
    } data_t;

    ctrl_t             id_ctrl, ctrl_d, ctrl_q;
    data_t             id_data, data_d, data_q;
    logic [REG_AW-1:0] rd_d, rd_q;
    logic              valid_d, valid_q;
    logic [CNT_W-1:0]  bubble_count_d, bubble_count_q;
    logic              uses_rs1, uses_rs2, hazard;

    assign id_ctrl = {id_alu_op, id_branch, id_mem_read, id_mem_to_reg,
                      id_mem_write, id_alu_src, id_reg_write};
    assign id_data = {id_pc, id_rs1_data, id_rs2_data, id_imm, id_opcode,
                      id_rs1, id_rs2, id_funct3, id_funct7};

    // Source-operand usage decoded from the opcode; unknown opcodes use neither.
    assign uses_rs2 = (id_opcode == OP_R) || (id_opcode == OP_S) || (id_opcode == OP_SB);
    assign uses_rs1 = uses_rs2 || (id_opcode == OP_LD) || (id_opcode == OP_ADDI);

    assign hazard = valid_q && ctrl_q.mem_read && (rd_q != '0) &&
                    ((uses_rs1 && (rd_q == id_rs1)) || (uses_rs2 && (rd_q == id_rs2)));

    // Flush wins over a stall: the held instruction is squashed anyway.
    assign pc_write    = !(hazard && !flush);
    assign if_id_write = !(hazard && !flush);

    always_comb begin
        ctrl_d         = id_ctrl;
        data_d         = id_data;
        rd_d           = id_rd;
        valid_d        = 1'b1;
        bubble_count_d = bubble_count_q;
        if (flush) begin
            ctrl_d  = '0;
            rd_d    = '0;
            valid_d = 1'b0;
        end else if (hazard) begin
            ctrl_d  = '0;
            rd_d    = '0;
            valid_d = 1'b0;
            if (!(&bubble_count_q)) begin
                bubble_count_d = bubble_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q         <= '0;
            data_q         <= '0;
            rd_q           <= '0;
            valid_q        <= 1'b0;
            bubble_count_q <= '0;
        end else begin
            ctrl_q         <= ctrl_d;
            data_q         <= data_d;
            rd_q           <= rd_d;
            valid_q        <= valid_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign ex_opcode     = data_q.opcode;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign ex_branch     = ctrl_q.branch;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_pc         = data_q.pc;
    assign ex_rs1_data   = data_q.rs1_data;
    assign ex_rs2_data   = data_q.rs2_data;
    assign ex_imm        = data_q.imm;
    assign ex_rs1        = data_q.rs1;
    assign ex_rs2        = data_q.rs2;
    assign ex_rd         = rd_q;
    assign ex_funct3     = data_q.funct3;
    assign ex_funct7     = data_q.funct7;
    assign ex_valid      = valid_q;
    assign bubble_count  = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a small pipeline model predicts stalls,
// bubbles, flushes and the saturating bubble counter.
module tb_id_ex_stage;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n, flush;
    logic [6:0]        id_opcode, ex_opcode;
    logic [1:0]        id_alu_op, ex_alu_op;
    logic              id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write;
    logic              ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
    logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd;
    logic [2:0]        id_funct3, ex_funct3;
    logic [6:0]        id_funct7, ex_funct7;
    logic              ex_valid, pc_write, if_id_write;
    logic [CNT_W-1:0]  bubble_count;

    id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .id_opcode(id_opcode), .id_alu_op(id_alu_op), .id_branch(id_branch),
        .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7(id_funct7),
        .ex_opcode(ex_opcode), .ex_alu_op(ex_alu_op), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .ex_valid(ex_valid), .pc_write(pc_write), .if_id_write(if_id_write),
        .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [7:0]  ctrl;
        logic [4:0]  rd;
        logic [15:0] cnt;
        logic        chk_data;
        logic [63:0] pc, rs1d, rs2d, imm;
        logic [26:0] misc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic        m_valid, m_mem_read;
    logic [4:0]  m_rd;
    logic [15:0] m_cnt;
    logic [63:0] pc_ctr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {alu_op, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write}
    function automatic logic [7:0] ctrl_of(input logic [6:0] op);
        case (op)
            7'b0110011: return 8'b10_000001;
            7'b0000011: return 8'b00_011011;
            7'b0100011: return 8'b00_000110;
            7'b1100011: return 8'b01_100000;
            7'b0010011: return 8'b00_000011;
            default:    return 8'b00_000000;
        endcase
    endfunction

    function automatic logic [7:0] ex_ctrl();
        return {ex_alu_op, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write};
    endfunction

    // Drive one ID instruction after a negedge, check stall outputs, push expectation.
    task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [63:0] imm, input logic f,
                         output logic hz);
        exp_t e;
        logic u1, u2, exp_pw;
        flush       = f;
        id_opcode   = op;
        {id_alu_op, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write} = ctrl_of(op);
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_imm      = imm;
        id_pc       = pc_ctr;
        id_rs1_data = {$urandom(), $urandom()};
        id_rs2_data = {$urandom(), $urandom()};
        id_funct3   = 3'($urandom_range(0, 7));
        id_funct7   = 7'($urandom());
        #1;
        u2 = (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
        u1 = u2 || (op == 7'b0000011) || (op == 7'b0010011);
        hz = m_valid && m_mem_read && (m_rd != 5'd0) &&
             ((u1 && (m_rd == rs1)) || (u2 && (m_rd == rs2)));
        exp_pw = !(hz && !f);
        check_eq("pc_write", 64'(pc_write), 64'(exp_pw));
        check_eq("if_id_write", 64'(if_id_write), 64'(exp_pw));
        e.cnt      = m_cnt;
        e.chk_data = !f;
        e.pc       = id_pc;
        e.rs1d     = id_rs1_data;
        e.rs2d     = id_rs2_data;
        e.imm      = imm;
        e.misc     = {id_funct7, id_funct3, rs1, rs2, op};
        if (f || hz) begin
            e.valid = 1'b0;
            e.ctrl  = 8'h00;
            e.rd    = 5'd0;
            if (!f && m_cnt != 16'hFFFF) e.cnt = m_cnt + 16'd1;
        end else begin
            e.valid = 1'b1;
            e.ctrl  = ctrl_of(op);
            e.rd    = rd;
        end
        sb.push_back(e);
        m_valid    = e.valid;
        m_mem_read = e.ctrl[4];
        m_rd       = e.rd;
        m_cnt      = e.cnt;
        if (!hz) pc_ctr = pc_ctr + 64'd4;
    endtask

    task automatic clock_and_compare(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq({tag, ".valid"}, 64'(ex_valid), 64'(e.valid));
        check_eq({tag, ".ctrl"}, 64'(ex_ctrl()), 64'(e.ctrl));
        check_eq({tag, ".rd"}, 64'(ex_rd), 64'(e.rd));
        check_eq({tag, ".cnt"}, 64'(bubble_count), 64'(e.cnt));
        if (e.chk_data) begin
            check_eq({tag, ".pc"}, ex_pc, e.pc);
            check_eq({tag, ".rs1d"}, ex_rs1_data, e.rs1d);
            check_eq({tag, ".rs2d"}, ex_rs2_data, e.rs2d);
            check_eq({tag, ".imm"}, ex_imm, e.imm);
            check_eq({tag, ".fields"}, 64'({ex_funct7, ex_funct3, ex_rs1, ex_rs2, ex_opcode}), 64'(e.misc));
        end
        @(negedge clk);
    endtask

    // Issue an instruction; if the model predicts a stall, re-present it once.
    task automatic issue(input string tag, input logic [6:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [63:0] imm,
                         input logic f);
        logic hz;
        drive(op, rs1, rs2, rd, imm, f, hz);
        clock_and_compare(tag);
        if (hz && !f) begin
            drive(op, rs1, rs2, rd, imm, 1'b0, hz);
            clock_and_compare({tag, "_retry"});
        end
    endtask

    task automatic model_reset();
        m_valid    = 1'b0;
        m_mem_read = 1'b0;
        m_rd       = 5'd0;
        m_cnt      = 16'd0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, ".valid"}, 64'(ex_valid), 64'd0);
        check_eq({tag, ".ctrl"}, 64'(ex_ctrl()), 64'd0);
        check_eq({tag, ".rd"}, 64'(ex_rd), 64'd0);
        check_eq({tag, ".cnt"}, 64'(bubble_count), 64'd0);
        check_eq({tag, ".imm"}, ex_imm, 64'd0);
        check_eq({tag, ".pc"}, ex_pc, 64'd0);
        check_eq({tag, ".pc_write"}, 64'(pc_write), 64'd1);
        check_eq({tag, ".if_id_write"}, 64'(if_id_write), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hz;
        reset_n = 1'b0;
        pc_ctr  = 64'h1000;
        model_reset();
        drive(7'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, hz);
        sb.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_state("reset");
        reset_n = 1'b1;

        issue("add3", 7'b0110011, 5'd1, 5'd2, 5'd3, 64'd0, 1'b0);
        issue("ld5", 7'b0000011, 5'd1, 5'd0, 5'd5, 64'd0, 1'b0);
        issue("add_dep", 7'b0110011, 5'd5, 5'd7, 5'd6, 64'd0, 1'b0);
        issue("ld0", 7'b0000011, 5'd1, 5'd0, 5'd0, 64'd16, 1'b0);
        issue("add_x0", 7'b0110011, 5'd0, 5'd7, 5'd6, 64'd0, 1'b0);
        issue("ld5b", 7'b0000011, 5'd1, 5'd0, 5'd5, 64'd8, 1'b0);
        issue("addi_dep", 7'b0010011, 5'd5, 5'd0, 5'd6, 64'd4, 1'b0);
        issue("ld5c", 7'b0000011, 5'd1, 5'd0, 5'd5, 64'd8, 1'b0);
        issue("addi_rs2", 7'b0010011, 5'd1, 5'd5, 5'd6, 64'd4, 1'b0);
        issue("ld5d", 7'b0000011, 5'd1, 5'd0, 5'd5, 64'd24, 1'b0);
        issue("beq_dep", 7'b1100011, 5'd1, 5'd5, 5'd0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
        issue("ld5e", 7'b0000011, 5'd1, 5'd0, 5'd5, 64'd0, 1'b0);
        issue("unknown", 7'b1111111, 5'd5, 5'd5, 5'd9, 64'd0, 1'b0);
        issue("ld5f", 7'b0000011, 5'd1, 5'd0, 5'd5, 64'd0, 1'b0);
        issue("flush_hz", 7'b0110011, 5'd5, 5'd7, 5'd6, 64'd0, 1'b1);
        issue("after_flush", 7'b0110011, 5'd5, 5'd7, 5'd6, 64'd0, 1'b0);

        force dut.bubble_count_q = 16'hFFFF;
        #1;
        release dut.bubble_count_q;
        m_cnt = 16'hFFFF;
        check_eq("cnt_preload", 64'(bubble_count), 64'hFFFF);
        issue("ld5_sat", 7'b0000011, 5'd1, 5'd0, 5'd5, 64'd0, 1'b0);
        issue("add_sat", 7'b0110011, 5'd5, 5'd7, 5'd6, 64'd0, 1'b0);

        issue("ld5_rst", 7'b0000011, 5'd1, 5'd0, 5'd5, 64'd0, 1'b0);
        drive(7'b0110011, 5'd5, 5'd7, 5'd6, 64'd0, 1'b0, hz);
        #1;
        reset_n = 1'b0;
        #1;
        sb.delete();
        model_reset();
        check_reset_state("mid_stall_reset");
        @(negedge clk);
        reset_n = 1'b1;
        issue("sd", 7'b0100011, 5'd1, 5'd2, 5'd0, 64'd8, 1'b0);
        issue("add_after", 7'b0110011, 5'd3, 5'd4, 5'd10, 64'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
